// File: rtl/seq_mult_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // ceil(log2(w+1)): bits needed to hold the iteration count w itself
    function automatic int cnt_width(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((64'sd1 << i) < longint'(w + 1)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_iter.sv
// WIDTH-cycle shift-add multiplier with valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN to add the i_signed port and two's-complement mode.
module seq_mult_iter
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     i_data_a,
    input  logic [WIDTH-1:0]     i_data_b,
    input  logic                 i_valid,
    output logic                 o_ready,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 i_signed,
`endif
    output logic [2*WIDTH-1:0]   o_data,
    output logic                 o_valid,
    input  logic                 i_ready
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("seq_mult_iter: WIDTH out of legal range");
    end

    state_e              state_r;
    logic [PW-1:0]       a_r;
    logic [WIDTH-1:0]    b_r;
    logic [PW-1:0]       acc_r;
    logic [CW-1:0]       cnt_r;
    logic                o_ready_r;
    logic                o_valid_r;

    logic [WIDTH-1:0]    mag_a_s;
    logic [WIDTH-1:0]    mag_b_s;
    logic [PW-1:0]       sum_s;
    logic [PW-1:0]       final_s;

`ifdef SEQ_MULT_SIGNED_EN
    logic                sign_r;
    logic                neg_a_s;
    logic                neg_b_s;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
    always_comb begin
        neg_a_s = i_signed & i_data_a[WIDTH-1];
        neg_b_s = i_signed & i_data_b[WIDTH-1];
        if (neg_a_s) begin
            mag_a_s = ~i_data_a + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_a_s = i_data_a;
        end
        if (neg_b_s) begin
            mag_b_s = ~i_data_b + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_b_s = i_data_b;
        end
    end
`else
    assign mag_a_s = i_data_a;
    assign mag_b_s = i_data_b;
`endif

    // One shift-add step, plus the sign fix-up applied on the final iteration
    always_comb begin
        if (b_r[0]) begin
            sum_s = acc_r + a_r;
        end else begin
            sum_s = acc_r;
        end
`ifdef SEQ_MULT_SIGNED_EN
        if (sign_r) begin
            final_s = ~sum_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            final_s = sum_s;
        end
`else
        final_s = sum_s;
`endif
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            a_r       <= {PW{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_r     <= {PW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            o_ready_r <= 1'b1;
            o_valid_r <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_r       <= {{WIDTH{1'b0}}, mag_a_s};
                        b_r       <= mag_b_s;
                        acc_r     <= {PW{1'b0}};
                        cnt_r     <= CNT_LOAD;
                        o_ready_r <= 1'b0;
                        state_r   <= ST_BUSY;
`ifdef SEQ_MULT_SIGNED_EN
                        sign_r    <= neg_a_s ^ neg_b_s;
`endif
                    end
                end
                ST_BUSY: begin
                    a_r   <= {a_r[PW-2:0], 1'b0};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        acc_r     <= final_s;
                        o_valid_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        acc_r     <= sum_s;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid_r <= 1'b0;
                        o_ready_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    o_valid_r <= 1'b0;
                    o_ready_r <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready = o_ready_r;
    assign o_valid = o_valid_r;
    assign o_data  = acc_r;

endmodule

// File: tb/tb_seq_mult_iter.sv
// Scoreboard bench for seq_mult_iter at WIDTH=8: directed cases plus randomized traffic.
module tb_seq_mult_iter;

    localparam int W  = 8;
    localparam int PW = 2 * W;
`ifdef SEQ_MULT_SIGNED_EN
    localparam bit HAS_SIGNED = 1'b1;
`else
    localparam bit HAS_SIGNED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  i_data_a = '0;
    logic [W-1:0]  i_data_b = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
`ifdef SEQ_MULT_SIGNED_EN
    logic          i_signed = 1'b0;
`endif
    logic [PW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b1;

    seq_mult_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
`ifdef SEQ_MULT_SIGNED_EN
        .i_signed (i_signed),
`endif
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PW-1:0] exp_q[$];
    int            acc_q[$];
    int            pass_cnt = 0;
    int            chk_cnt  = 0;
    int            hs_cyc   = 0;
    int            n_out    = 0;
    bit            rand_phase = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer multiply of the operands as the mode interprets them
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint pa, pb, p;
        if (s && HAS_SIGNED) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[PW-1:0];
    endfunction

    // Present operands (caller is just after a rising edge) and wait for acceptance
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int acc_c);
        i_data_a = a;
        i_data_b = b;
`ifdef SEQ_MULT_SIGNED_EN
        i_signed = s;
`endif
        i_valid = 1'b1;
        acc_c = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_ready && !rst) begin
                exp_q.push_back(ref_mul(a, b, s));
                acc_c = cyc + 1;
                acc_q.push_back(acc_c);
                break;
            end
        end
        if (acc_c < 0) check("accept_timeout", 0, 1);
        @(posedge clk);
        #2;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: compares each product handshake against the scoreboard
    initial begin : monitor
        logic          prev_valid;
        logic [PW-1:0] prev_data;
        prev_valid = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (o_valid) begin
                    check("o_ready_low_in_done", o_ready, 0);
                    if (!prev_valid) begin
                        if (acc_q.size() == 0) check("unexpected_output", 1, 0);
                        else check("latency", cyc - acc_q[0], W);
                    end else begin
                        check("o_data_hold", o_data, prev_data);
                    end
                    if (i_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", 1, 0);
                        end else begin
                            check("product", o_data, exp_q.pop_front());
                            if (acc_q.size() != 0) void'(acc_q.pop_front());
                            hs_cyc = cyc + 1;
                            n_out++;
                        end
                    end
                end
                prev_valid = o_valid;
                prev_data  = o_data;
            end
        end
    end

    // Random consumer back-pressure during the random phase
    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #3;
            if (rand_phase) i_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : stimulus
        int t1, t2, n_before;
        logic [W-1:0] ra, rb;
        logic rs;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_o_ready", o_ready, 1);
        check("reset_o_valid", o_valid, 0);
        check("reset_o_data", o_data, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        issue(8'd200, 8'd250, 1'b0, t1);
        drain();

        issue(8'h00, 8'hFF, 1'b0, t1);
        issue(8'hFF, 8'hFF, 1'b0, t2);
        check("b2b_accept_gap", t2 - t1, W + 2);
        drain();

        i_ready = 1'b0;
        issue(8'h5A, 8'h3C, 1'b0, t1);
        fork
            issue(8'h01, 8'h01, 1'b0, t2);
            begin
                for (int n = 0; n < 100; n++) begin
                    @(negedge clk);
                    if (o_valid) break;
                end
                repeat (5) @(posedge clk);
                #2;
                i_ready = 1'b1;
            end
        join
        check("bp_accept_after_handshake", (t2 > hs_cyc), 1);
        drain();

        n_before = n_out;
        issue(8'd3, 8'd7, 1'b0, t1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_o_ready", o_ready, 1);
        check("midreset_o_valid", o_valid, 0);
        check("midreset_o_data", o_data, 0);
        repeat (20) @(posedge clk);
        #2;
        check("midreset_no_product", n_out, n_before);

`ifdef SEQ_MULT_SIGNED_EN
        issue(8'hFD, 8'h05, 1'b1, t1);
        issue(8'h80, 8'h80, 1'b1, t1);
        issue(8'h7F, 8'hFF, 1'b1, t1);
        issue(8'hFD, 8'h05, 1'b0, t1);
        drain();
`endif

        issue(8'hFF, 8'h00, 1'b1, t1);
        issue(8'h80, 8'hFF, 1'b1, t1);
        drain();

        rand_phase = 1'b1;
        for (int k = 0; k < 30; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            issue(ra, rb, rs, t1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
        end
        rand_phase = 1'b0;
        #1;
        i_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seq_mult_iter.md
# seq_mult_iter

Parametrised iterative shift-add multiplier that replaces the single-cycle combinational ALU multiply with a WIDTH-cycle sequential unit producing the full 2·WIDTH-bit product. It sits on the ALU result path behind the operand registers. A valid/ready handshake on both sides lets the sequencer stall on it. Optional signed (two's-complement) mode is compile-time selectable.

## Interface
- `WIDTH`, default 16: operand width in bits, legal 2..32.
- `clk`  in  1: system clock, all logic rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `i_data_a`  in  WIDTH: multiplicand.
- `i_data_b`  in  WIDTH: multiplier.
- `i_valid`  in  1: operands valid.
- `o_ready`  out  1: unit can accept operands.
- `i_signed`  in  1: per-operation signed select (present only with `SEQ_MULT_SIGNED_EN`).
- `o_data`  out  2·WIDTH: product.
- `o_valid`  out  1: product valid.
- `i_ready`  in  1: consumer accepts product.

## Operation
- FSM states: IDLE, BUSY, DONE; reset → IDLE.
- IDLE: `o_ready`=1. On `i_valid & o_ready`, the unit latches the operands into an A register (2·WIDTH, zero-extended) and a B shift register. It clears the accumulator, loads the counter with WIDTH, and moves to BUSY.
- BUSY: each cycle, if B[0]=1 then acc += A. Then A <<= 1, B >>= 1, counter −1. When the counter reaches 1 this cycle, go to DONE.
- DONE: `o_valid`=1 and `o_data`=acc, both held stable until `i_valid`… until `i_ready`=1. On `o_valid & i_ready`, go to IDLE.
- No early termination on B=0; latency is fixed.
- Arithmetic is unsigned modulo 2^(2·WIDTH). The full product always fits, so there is no overflow.
- `o_ready`=0 in BUSY and DONE. `i_valid` there is ignored and operands are not sampled.
- Reset mid-operation (any state): next cycle IDLE. Acc, counter and operand registers are cleared, and any partial result is discarded without an `o_valid`.
- Operand zero / all-ones are handled with no special case.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_ready`=1.
- Accept on edge T. BUSY covers edges T+1..T+WIDTH. `o_valid` rises after edge T+WIDTH, so it is seen in cycle T+WIDTH+1.
- With `i_ready` held high, the unit can accept a new operation every WIDTH+2 cycles (accept, WIDTH iterations, DONE/handshake cycle).
- `o_ready` is purely a function of state (no combinational path from `i_ready` or `i_valid`).
- `o_data` is registered and holds its value in DONE regardless of input activity.

## Configuration
- `SEQ_MULT_SIGNED_EN` defined:
  - The `i_signed` port exists and is sampled with the operands.
  - If it is 1, the unit latches |a| and |b| and records sign = a[MSB]^b[MSB].
  - On the DONE transition it writes acc = −acc when sign=1.
  - −2^(WIDTH−1) × −2^(WIDTH−1) = 2^(2·WIDTH−2) must be exact.
  - Latency is unchanged, because the negation is folded into the last BUSY cycle.
- Not defined: no `i_signed` port, unsigned only, no negation logic.

## Structure
- Package `seq_mult_pkg` holds:
  - the FSM state enum (IDLE/BUSY/DONE);
  - the counter-width function ceil(log2(WIDTH+1));
  - the legal WIDTH bounds used by an elaboration-time check.
- No sub-module is natural. The datapath (acc, shifters, counter) and FSM live in one module.

## Test plan
- WIDTH=8, unsigned: a=200, b=250, `i_ready`=1 → `o_valid` in cycle T+9, `o_data`=0xC350, one-cycle pulse.
- WIDTH=8, back-to-back operations 0×0xFF then 0xFF×0xFF → `o_data`=0x0000 then 0xFE01. Second accept no earlier than 10 cycles after the first.
- Back-pressure: `i_ready`=0 for 5 cycles after `o_valid` → `o_data` stable, `o_ready`=0, and a new `i_valid` with a=1, b=1 is not accepted until the product handshake completes.
- Reset asserted in BUSY iteration 4 of 3×7 → next cycle `o_ready`=1, `o_valid`=0, `o_data`=0, and no product is emitted.
- `SEQ_MULT_SIGNED_EN`, WIDTH=8, `i_signed`=1:
  - −3×5 → 0xFFF1
  - −128×−128 → 0x4000
  - 127×−1 → 0xFF81
- `SEQ_MULT_SIGNED_EN`, `i_signed`=0, a=0xFD, b=0x05 → 0x04F1 (unsigned interpretation).
